bullet_controller: RTL and testbench
====================================

Name: bullet_controller

Overview:
Player-side owner of the single player bullet: launches it from the player ship on fire, advances it once per frame, and retires it on hit or at the top of the screen. Drives the bullet position and `loaded` consumed by the hit detector, and consumes that detector's `bulletHit`. Sits between the keyboard/ship logic and the collision logic in the game core.

Parameters:
BULLET_SPEED, 8, pixels the bullet rises per frame_tick
SHIP_HALF_H, 16, launch offset above ship centre (pixels)
TOP_Y, 0, topmost legal bullet Y
PARK_X, 10'd1023, off-screen X while not flying
PARK_Y, 10'd1023, off-screen Y while not flying
COOLDOWN_FRAMES, 4, frames after reload before next launch allowed

Ports:
Clk  input  1  system clock
Reset_n  input  1  asynchronous active-low reset
frame_tick  input  1  one-Clk pulse per video frame, Clk domain
fire  input  1  fire key level
ShipX  input  10  player ship centre X
ShipY  input  10  player ship centre Y
bulletHit  input  1  hit flag from the hit detector, level, held until `loaded`
BulletX  output  10  bullet centre X
BulletY  output  10  bullet centre Y
bullet_active  output  1  high while the bullet is flying
loaded  output  1  high while the bullet is parked; clears the hit detector's latch
hit_count  output  8  count of bullets retired by a hit, saturating at 255

Behaviour:
- Single clock Clk; Reset_n is asynchronous, active-low. All outputs are registered.
- Reset values: state = LOADED, BulletX = PARK_X, BulletY = PARK_Y, bullet_active = 0, loaded = 1, hit_count = 0, cooldown = 0, armed = 1.
- States:
  - LOADED: bullet parked at PARK_X/PARK_Y; loaded = 1; bullet_active = 0.
  - FLYING: loaded = 0; bullet_active = 1.
  - SPENT: bullet parked; loaded = 0; bullet_active = 0. Lasts exactly one frame.
- `armed` (fire edge qualifier):
  - Cleared on launch.
  - Set on any Clk where fire = 0.
- LOADED:
  - On frame_tick with cooldown != 0: cooldown decrements.
  - On frame_tick with cooldown == 0, fire = 1 and armed = 1: go to FLYING.
  - Launch values: BulletX = ShipX; BulletY = ShipY - SHIP_HALF_H, clamped to TOP_Y if ShipY < TOP_Y + SHIP_HALF_H.
  - New values are visible one Clk after the tick edge.
  - fire is sampled only on frame_tick; a tap released between ticks is lost.
- FLYING:
  - bulletHit is checked every Clk, not only on ticks, and takes priority. bulletHit = 1 → SPENT on the next edge; hit_count += 1, saturating.
  - Else on frame_tick: if BulletY < TOP_Y + BULLET_SPEED → SPENT, with no subtraction and no wrap. Otherwise BulletY -= BULLET_SPEED.
  - BulletX holds during flight; ship movement does not steer the bullet.
- SPENT:
  - bulletHit is ignored.
  - On frame_tick: go to LOADED and load cooldown = COOLDOWN_FRAMES.
- Simultaneous bulletHit and top-boundary tick: counted as a hit.
- bulletHit is ignored in LOADED and SPENT. The detector latch is cleared through `loaded`.
- Reset_n asserted mid-flight: immediate return to the reset values. hit_count is cleared.
- Arithmetic: 10-bit unsigned. Boundary comparisons are made before the subtraction, so no underflow is possible.

Optional Feature:
AUTOFIRE_EN
- Defined: the armed requirement is removed. Holding fire relaunches as soon as LOADED is reached with cooldown == 0.
- Undefined: fire must be observed low at least one Clk between launches.

Decomposition:
- Shared package invaders_pkg:
  - typedef enum logic [1:0] bullet_state_t {LOADED, FLYING, SPENT}
  - screen constants SCREEN_W = 640 and SCREEN_H = 480
  - PARK_X/PARK_Y defaults
- One natural sub-module: bullet_fire_arm, containing the armed flag, the cooldown counter and the AUTOFIRE_EN handling. It outputs fire_ok.

Test Plan:
- Reset_n = 0 mid-flight → next Clk: BulletX = 1023, BulletY = 1023, loaded = 1, bullet_active = 0, hit_count = 0.
- Launch: ShipX = 320, ShipY = 440, fire = 1 on a tick after reset → BulletX = 320, BulletY = 424, bullet_active = 1, loaded = 0. The next tick gives BulletY = 416.
- Top retire, no hit:
  - Launch at 424 → tick 53 gives BulletY = 0; tick 54 → SPENT; tick 55 → LOADED with cooldown = 4.
  - Held fire does not relaunch.
  - Release then press: launch occurs on the 5th tick after reload.
- Hit: bulletHit = 1 between ticks while FLYING → SPENT on the next Clk, hit_count = 1. On the following tick loaded = 1.
- Simultaneous: BulletY = 4 with bulletHit = 1 on a tick → hit_count increments once, SPENT.
- Clamp: ShipY = 10 launch → BulletY = 0; the next tick → SPENT. With AUTOFIRE_EN defined and fire held, relaunches occur every 7 ticks (1 SPENT frame, 1 LOADED arrival tick, 4 cooldown ticks, then 1 launch tick — recheck against the state definitions).

Source files
------------

// File: rtl/invaders_pkg.sv
// Shared game-core types and constants for the invaders design.
package invaders_pkg;

    typedef enum logic [1:0] {
        LOADED = 2'd0,
        FLYING = 2'd1,
        SPENT  = 2'd2
    } bullet_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam logic [9:0] DEF_PARK_X = 10'd1023;
    localparam logic [9:0] DEF_PARK_Y = 10'd1023;

endpackage

// File: rtl/bullet_fire_arm.sv
// Launch qualifier: post-reload cooldown counter plus fire-edge arming.
// Optional macro AUTOFIRE_EN drops the arming requirement so held fire relaunches.
module bullet_fire_arm #(
    parameter int COOLDOWN_FRAMES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_tick,
    input  logic fire,
    input  logic in_loaded,
    input  logic launch,
    input  logic reload,
    output logic fire_ok
);
    import invaders_pkg::*;

    localparam int CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);
    localparam logic [CD_W-1:0] CD_ZERO = CD_W'(0);
    localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);

    logic [CD_W-1:0] cooldown_r;

    // Cooldown reloads on return to LOADED and counts down one per parked frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cooldown_r <= CD_ZERO;
        end else if (reload) begin
            cooldown_r <= CD_LOAD;
        end else if (in_loaded && frame_tick && (cooldown_r != CD_ZERO)) begin
            cooldown_r <= cooldown_r - CD_ONE;
        end else begin
            cooldown_r <= cooldown_r;
        end
    end

`ifdef AUTOFIRE_EN
    // Held fire is enough once the cooldown has expired.
    always_comb begin
        fire_ok = fire && (cooldown_r == CD_ZERO) && (launch || !launch);
    end
`else
    logic armed_r;

    // Armed whenever fire is seen low; a launch consumes the arming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_r <= 1'b1;
        end else if (!fire) begin
            armed_r <= 1'b1;
        end else if (launch) begin
            armed_r <= 1'b0;
        end else begin
            armed_r <= armed_r;
        end
    end

    // Fire must be freshly pressed and the cooldown expired.
    always_comb begin
        fire_ok = fire && armed_r && (cooldown_r == CD_ZERO);
    end
`endif

endmodule

// File: rtl/bullet_controller.sv
// Owner of the single player bullet: launch, per-frame advance, retire on hit or top.
// Optional macro AUTOFIRE_EN (handled in bullet_fire_arm) enables held-fire relaunch.
module bullet_controller
    import invaders_pkg::*;
#(
    parameter int         BULLET_SPEED    = 8,
    parameter int         SHIP_HALF_H     = 16,
    parameter int         TOP_Y           = 0,
    parameter logic [9:0] PARK_X          = DEF_PARK_X,
    parameter logic [9:0] PARK_Y          = DEF_PARK_Y,
    parameter int         COOLDOWN_FRAMES = 4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       fire,
    input  logic [9:0] ShipX,
    input  logic [9:0] ShipY,
    input  logic       bulletHit,
    output logic [9:0] BulletX,
    output logic [9:0] BulletY,
    output logic       bullet_active,
    output logic       loaded,
    output logic [7:0] hit_count
);

    localparam logic [9:0] TOP_W      = 10'(TOP_Y);
    localparam logic [9:0] HALF_W     = 10'(SHIP_HALF_H);
    localparam logic [9:0] SPEED_W    = 10'(BULLET_SPEED);
    localparam logic [9:0] LAUNCH_MIN = 10'(TOP_Y + SHIP_HALF_H);
    localparam logic [9:0] RETIRE_LT  = 10'(TOP_Y + BULLET_SPEED);

    bullet_state_t state_r, state_n;
    logic [9:0]    x_n, y_n;
    logic [7:0]    hits_n;
    logic          launch_s, reload_s, fire_ok_s;

    bullet_fire_arm #(
        .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
    ) u_fire_arm (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .frame_tick(frame_tick),
        .fire      (fire),
        .in_loaded (state_r == LOADED),
        .launch    (launch_s),
        .reload    (reload_s),
        .fire_ok   (fire_ok_s)
    );

    // Next state and next bullet values; boundary tests precede any subtraction.
    always_comb begin
        state_n  = state_r;
        x_n      = BulletX;
        y_n      = BulletY;
        hits_n   = hit_count;
        launch_s = 1'b0;
        reload_s = 1'b0;
        case (state_r)
            LOADED: begin
                if (frame_tick && fire_ok_s) begin
                    state_n  = FLYING;
                    launch_s = 1'b1;
                    x_n      = ShipX;
                    if (ShipY < LAUNCH_MIN) begin
                        y_n = TOP_W;
                    end else begin
                        y_n = ShipY - HALF_W;
                    end
                end else begin
                    state_n = LOADED;
                end
            end
            FLYING: begin
                if (bulletHit) begin
                    state_n = SPENT;
                    x_n     = PARK_X;
                    y_n     = PARK_Y;
                    if (hit_count != 8'd255) begin
                        hits_n = hit_count + 8'd1;
                    end else begin
                        hits_n = hit_count;
                    end
                end else if (frame_tick) begin
                    if (BulletY < RETIRE_LT) begin
                        state_n = SPENT;
                        x_n     = PARK_X;
                        y_n     = PARK_Y;
                    end else begin
                        y_n = BulletY - SPEED_W;
                    end
                end else begin
                    state_n = FLYING;
                end
            end
            SPENT: begin
                if (frame_tick) begin
                    state_n  = LOADED;
                    reload_s = 1'b1;
                end else begin
                    state_n = SPENT;
                end
            end
            default: begin
                state_n = LOADED;
                x_n     = PARK_X;
                y_n     = PARK_Y;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r       <= LOADED;
            BulletX       <= PARK_X;
            BulletY       <= PARK_Y;
            bullet_active <= 1'b0;
            loaded        <= 1'b1;
            hit_count     <= 8'd0;
        end else begin
            state_r       <= state_n;
            BulletX       <= x_n;
            BulletY       <= y_n;
            bullet_active <= (state_n == FLYING);
            loaded        <= (state_n == LOADED);
            hit_count     <= hits_n;
        end
    end

endmodule

// File: tb/tb_bullet_controller.sv
// Directed bench for bullet_controller: per-cycle model compare plus literal pins.
module tb_bullet_controller;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b1;
    logic       frame_tick = 1'b0;
    logic       fire = 1'b0;
    logic [9:0] ShipX = 10'd320;
    logic [9:0] ShipY = 10'd440;
    logic       bulletHit = 1'b0;
    logic [9:0] BulletX, BulletY;
    logic       bullet_active, loaded;
    logic [7:0] hit_count;

`ifdef AUTOFIRE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    bullet_controller dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_tick   (frame_tick),
        .fire         (fire),
        .ShipX        (ShipX),
        .ShipY        (ShipY),
        .bulletHit    (bulletHit),
        .BulletX      (BulletX),
        .BulletY      (BulletY),
        .bullet_active(bullet_active),
        .loaded       (loaded),
        .hit_count    (hit_count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 parked, 1 in flight, 2 spent frame.
    int m_mode, m_x, m_y, m_hits, m_cd;
    bit m_armed;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_mode <= 0; m_x <= 1023; m_y <= 1023; m_hits <= 0; m_cd <= 0; m_armed <= 1'b1;
        end else begin
            if (!fire) m_armed <= 1'b1;
            if (m_mode == 0 && frame_tick) begin
                if (m_cd > 0) m_cd <= m_cd - 1;
                else if (fire && (m_armed || AUTO)) begin
                    m_mode  <= 1;
                    m_x     <= int'(ShipX);
                    m_y     <= (int'(ShipY) >= 16) ? int'(ShipY) - 16 : 0;
                    m_armed <= 1'b0;
                end
            end else if (m_mode == 1 && bulletHit) begin
                m_mode <= 2; m_x <= 1023; m_y <= 1023;
                m_hits <= (m_hits + 1 > 255) ? 255 : m_hits + 1;
            end else if (m_mode == 1 && frame_tick) begin
                if (m_y >= 8) m_y <= m_y - 8;
                else begin m_mode <= 2; m_x <= 1023; m_y <= 1023; end
            end else if (m_mode == 2 && frame_tick) begin
                m_mode <= 0; m_cd <= 4;
            end
        end
    end

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge Clk) begin
        if (cmp_en) begin
            check("mdl_x", BulletX, m_x);
            check("mdl_y", BulletY, m_y);
            check("mdl_active", bullet_active, (m_mode == 1));
            check("mdl_loaded", loaded, (m_mode == 0));
            check("mdl_hits", hit_count, m_hits);
        end
    end

    task automatic tick();
        @(posedge Clk); #2 frame_tick = 1'b1;
        @(posedge Clk); #2 frame_tick = 1'b0;
    endtask

    task automatic rearm();
        @(posedge Clk); #2 fire = 1'b0;
        @(posedge Clk); #2 fire = 1'b1;
    endtask

    task automatic hit_now();
        @(posedge Clk); #2 bulletHit = 1'b1;
        @(posedge Clk); #2;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 Reset_n = 1'b0;
        #2 cmp_en = 1'b1;
        repeat (2) @(posedge Clk);
        check("rst_x", BulletX, 1023);
        check("rst_y", BulletY, 1023);
        check("rst_loaded", loaded, 1);
        check("rst_active", bullet_active, 0);
        check("rst_hits", hit_count, 0);
        #2 Reset_n = 1'b1;

`ifndef AUTOFIRE_EN
        // Launch and first advance.
        fire = 1'b1;
        tick();
        check("launch_x", BulletX, 320);
        check("launch_y", BulletY, 424);
        check("launch_active", bullet_active, 1);
        check("launch_loaded", loaded, 0);
        tick();
        check("adv_y", BulletY, 416);
        repeat (52) tick();
        check("top_y0", BulletY, 0);
        check("top_active", bullet_active, 1);
        tick();
        check("spent_active", bullet_active, 0);
        check("spent_loaded", loaded, 0);
        check("spent_x", BulletX, 1023);
        tick();
        check("reload_loaded", loaded, 1);
        repeat (5) tick();
        check("held_no_relaunch", loaded, 1);

        // Hit between ticks.
        rearm();
        tick();
        check("relaunch_y", BulletY, 424);
        fire = 1'b0;
        hit_now();
        check("hit_active", bullet_active, 0);
        check("hit_loaded", loaded, 0);
        check("hit_count1", hit_count, 1);
        tick();
        bulletHit = 1'b0;
        check("hit_reload", loaded, 1);

        // Launch on the fifth tick after reload.
        ShipY = 10'd20;
        fire  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("cooldown_hold", loaded, 1);
        end
        tick();
        check("cd_launch_active", bullet_active, 1);
        check("cd_launch_y", BulletY, 4);

        // Hit and top boundary on the same tick counts once.
        @(posedge Clk); #2 frame_tick = 1'b1; bulletHit = 1'b1;
        @(posedge Clk); #2 frame_tick = 1'b0;
        check("sim_hits", hit_count, 2);
        check("sim_active", bullet_active, 0);
        tick();
        bulletHit = 1'b0;
        check("sim_reload", loaded, 1);

        // Clamp at the top edge.
        ShipY = 10'd10;
        rearm();
        repeat (5) tick();
        check("clamp_y", BulletY, 0);
        check("clamp_active", bullet_active, 1);
        tick();
        check("clamp_spent", bullet_active, 0);
        check("clamp_spent_loaded", loaded, 0);
        tick();

        // Drive hit_count to saturation.
        ShipY = 10'd440;
        for (int i = 0; i < 254; i++) begin
            rearm();
            repeat (5) tick();
            hit_now();
            tick();
            bulletHit = 1'b0;
        end
        check("sat_255", hit_count, 255);

        // Reset during flight.
        rearm();
        repeat (6) tick();
        check("pre_rst_active", bullet_active, 1);
        Reset_n = 1'b0;
        #1;
        check("async_rst_y", BulletY, 1023);
        check("async_rst_hits", hit_count, 0);
        @(posedge Clk); #2;
        check("midrst_x", BulletX, 1023);
        check("midrst_loaded", loaded, 1);
        check("midrst_active", bullet_active, 0);
        Reset_n = 1'b1;
        tick();
        check("post_rst_launch", BulletY, 424);
`else
        // Held fire relaunches every seventh tick.
        ShipY = 10'd10;
        fire  = 1'b1;
        tick();
        check("af_launch_y", BulletY, 0);
        check("af_launch_active", bullet_active, 1);
        for (int r = 0; r < 2; r++) begin
            for (int k = 1; k <= 7; k++) begin
                tick();
                check("af_period", bullet_active, (k == 7));
            end
        end
        fire = 1'b0;
`endif
        repeat (3) @(posedge Clk);
        #2 cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
